// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer: seeds the RNG from a free-running counter, grows the
// colour sequence by one random entry per round, plays it back and checks the player.
module simon_seq_ctrl #(
   parameter int  MAX_LEN        = 32,
   parameter int  SHOW_CYCLES    = 25_000_000,
   parameter int  GAP_CYCLES     = 12_500_000,
   parameter int  TIMEOUT_CYCLES = 250_000_000,
   localparam int LW             = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic [3:0]    btn_i,
   input  logic [1:0]    rnd_i,
   output logic [31:0]   seed_o,
   output logic          loadseed_o,
   output logic [3:0]    led_o,
   output logic          turn_o,
   output logic [LW-1:0] level_o,
   output logic          win_o,
   output logic          lose_o
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEED,
      S_SETTLE,
      S_APPEND,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_INPUT,
      S_GAP,
      S_WIN,
      S_LOSE
   } state_t;

   localparam logic [LW-1:0] LVL_ONE      = LW'(1);
   localparam logic [LW-1:0] LVL_MAX      = LW'(MAX_LEN);
   localparam logic [31:0]   SETTLE_LAST  = 32'd1;
   localparam logic [31:0]   SHOW_LAST    = 32'(SHOW_CYCLES - 1);
   localparam logic [31:0]   GAP_LAST     = 32'(GAP_CYCLES - 1);
   localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t        state_q;
   state_t        state_d;
   logic [31:0]   ent_q;
   logic [31:0]   tmr_q;
   logic [31:0]   tmr_d;
   logic [LW-1:0] idx_q;
   logic [LW-1:0] idx_d;
   logic [1:0]    mem_q [MAX_LEN];

   logic [31:0]   seed_d;
   logic          loadseed_d;
   logic          turn_d;
   logic          win_d;
   logic          lose_d;
   logic [3:0]    led_d;
   logic [LW-1:0] level_d;

   logic [1:0]    exp_col;
   logic [1:0]    show_col;
   logic [LW-1:0] idx_inc;
   logic          press;
   logic          press_ok;
   logic          last_entry;

   function automatic logic [3:0] col2led(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

   // Colour the player is expected to press next.
   always_comb begin
      exp_col = 2'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (LW'(i) == idx_q) exp_col = mem_q[i];
      end
   end

   assign idx_inc    = idx_q + LVL_ONE;
   assign press      = |btn_i;
   assign press_ok   = (btn_i == col2led(exp_col));
   assign last_entry = (idx_q == level_o - LVL_ONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_WIN, S_LOSE: if (start_i) state_d = S_SEED;
         S_SEED:                state_d = S_SETTLE;
         S_SETTLE:              if (tmr_q == SETTLE_LAST) state_d = S_APPEND;
         S_APPEND:              state_d = S_SHOW_ON;
         S_SHOW_ON:             if (tmr_q == SHOW_LAST) state_d = S_SHOW_OFF;
         S_SHOW_OFF: begin
            if (tmr_q == GAP_LAST) state_d = (idx_inc == level_o) ? S_INPUT : S_SHOW_ON;
         end
         S_INPUT: begin
            // A press in the expiry cycle wins over the timeout.
            if (press) begin
               if (!press_ok)       state_d = S_LOSE;
               else if (last_entry) state_d = (level_o == LVL_MAX) ? S_WIN : S_GAP;
            end else if (tmr_q == TIMEOUT_LAST) begin
               state_d = S_LOSE;
            end
         end
         S_GAP:                 if (tmr_q == GAP_LAST) state_d = S_APPEND;
         default:               state_d = S_IDLE;
      endcase
   end

   always_comb begin
      loadseed_d = (state_d == S_SEED);
      seed_d     = (state_d == S_SEED) ? ent_q : seed_o;
      turn_d     = (state_d == S_INPUT);
      win_d      = (state_d == S_WIN);
      lose_d     = (state_d == S_LOSE);
      level_d    = level_o;
      idx_d      = idx_q;
      tmr_d      = tmr_q + 32'd1;
      if (state_d != state_q || state_d inside {S_IDLE, S_WIN, S_LOSE}) tmr_d = '0;

      case (state_q)
         S_APPEND: begin
            idx_d = '0;
            if (level_o != LVL_MAX) level_d = level_o + LVL_ONE;
         end
         S_SHOW_OFF: begin
            if (tmr_q == GAP_LAST) idx_d = (idx_inc == level_o) ? '0 : idx_inc;
         end
         S_INPUT: begin
            if (press && press_ok && !last_entry) begin
               idx_d = idx_inc;
               tmr_d = '0;
            end
         end
         default: ;
      endcase
      if (state_d == S_SEED) level_d = '0;

      // The entry being appended is not in the store yet, so forward rnd_i.
      show_col = 2'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (LW'(i) == idx_d) show_col = mem_q[i];
      end
      if (state_q == S_APPEND && idx_d == level_o) show_col = rnd_i;
      led_d = (state_d == S_SHOW_ON) ? col2led(show_col) : 4'b0000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_q      <= '0;
         tmr_q      <= '0;
         idx_q      <= '0;
         seed_o     <= '0;
         loadseed_o <= 1'b0;
         led_o      <= 4'b0000;
         turn_o     <= 1'b0;
         level_o    <= '0;
         win_o      <= 1'b0;
         lose_o     <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= 2'd0;
      end else begin
         ent_q      <= ent_q + 32'd1;
         tmr_q      <= tmr_d;
         idx_q      <= idx_d;
         seed_o     <= seed_d;
         loadseed_o <= loadseed_d;
         led_o      <= led_d;
         turn_o     <= turn_d;
         level_o    <= level_d;
         win_o      <= win_d;
         lose_o     <= lose_d;
         if (state_q == S_APPEND) begin
            for (int i = 0; i < MAX_LEN; i++) begin
               if (LW'(i) == level_o) mem_q[i] <= rnd_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Bench for simon_seq_ctrl: a game-level model builds a per-cycle timeline of
// stimulus and expected outputs, which is replayed and compared every cycle.
module tb_simon_seq_ctrl;

   localparam int MAX_LEN = 3;
   localparam int SHOW    = 4;
   localparam int GAP     = 2;
   localparam int TMO     = 20;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start_i = 1'b0;
   logic [3:0]    btn_i = 4'd0;
   logic [1:0]    rnd_i = 2'd0;
   logic [31:0]   seed_o;
   logic          loadseed_o;
   logic [3:0]    led_o;
   logic          turn_o;
   logic [LW-1:0] level_o;
   logic          win_o;
   logic          lose_o;

   simon_seq_ctrl #(
      .MAX_LEN        (MAX_LEN),
      .SHOW_CYCLES    (SHOW),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i),
      .btn_i      (btn_i),
      .rnd_i      (rnd_i),
      .seed_o     (seed_o),
      .loadseed_o (loadseed_o),
      .led_o      (led_o),
      .turn_o     (turn_o),
      .level_o    (level_o),
      .win_o      (win_o),
      .lose_o     (lose_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic [3:0]  btn;
      logic [1:0]  rnd;
      logic [31:0] seed;
      logic        ld;
      logic [3:0]  led;
      logic        turn;
      int          level;
      logic        win;
      logic        lose;
      int          pin;
   } row_t;

   row_t rows[$];

   // Model of what the outputs must be during the cycle being built.
   int          cnt = 0;
   logic [31:0] m_seed = 0;
   logic        m_ld = 0;
   logic [3:0]  m_led = 0;
   logic        m_turn = 0;
   int          m_level = 0;
   logic        m_win = 0;
   logic        m_lose = 0;
   int          seq[$];
   int          pin_next = 0;

   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [1:0] rr();
      return 2'($urandom);
   endfunction

   function automatic logic [3:0] rb();
      return 4'($urandom);
   endfunction

   task automatic emit(input logic rst_v, input logic st, input logic [3:0] b, input logic [1:0] rn);
      row_t r;
      r.rst = rst_v; r.start = st; r.btn = b; r.rnd = rn;
      r.seed = m_seed; r.ld = m_ld; r.led = m_led; r.turn = m_turn;
      r.level = m_level; r.win = m_win; r.lose = m_lose; r.pin = pin_next;
      pin_next = 0;
      rows.push_back(r);
      cnt = rst_v ? cnt + 1 : 0;
   endtask

   task automatic busy(input int n);
      for (int i = 0; i < n; i++) emit(1'b1, 1'($urandom), rb(), rr());
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) emit(1'b1, 1'b0, rb(), rr());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) emit(1'b1, 1'($urandom), 4'd0, rr());
   endtask

   task automatic do_reset(input int n);
      m_seed = 0; m_ld = 0; m_led = 0; m_turn = 0; m_level = 0; m_win = 0; m_lose = 0;
      seq.delete();
      for (int i = 0; i < n; i++) emit(1'b0, 1'b0, rb(), rr());
   endtask

   task automatic start_seq(input int pin_seed);
      int c;
      c = cnt;
      seq.delete();
      emit(1'b1, 1'b1, rb(), rr());
      m_seed = 32'(c); m_ld = 1; m_level = 0; m_win = 0; m_lose = 0; m_led = 0; m_turn = 0;
      pin_next = pin_seed;
      busy(1);
      m_ld = 0;
      busy(2);
   endtask

   task automatic append(input int f);
      int v;
      v = (f < 0) ? int'($urandom_range(0, 3)) : f;
      emit(1'b1, 1'($urandom), rb(), 2'(v));
      seq.push_back(v);
      if (m_level < MAX_LEN) m_level++;
   endtask

   task automatic show();
      for (int i = 0; i < seq.size(); i++) begin
         m_led = 4'(1 << seq[i]);
         busy(SHOW);
         m_led = 0;
         busy(GAP);
      end
      m_turn = 1;
   endtask

   // mode 0: correct presses, 1: wrong press at entry k, 2: timeout at entry k,
   // 3: every correct press lands on the last allowed idle cycle.
   task automatic play(input int mode, input int k, input logic [3:0] wrong, output bit over);
      over = 0;
      for (int i = 0; i < seq.size() && !over; i++) begin
         int d;
         logic [3:0] good;
         logic [3:0] w;
         good = 4'(1 << seq[i]);
         if (mode == 2 && i == k) begin
            idle(TMO);
            m_turn = 0; m_lose = 1; over = 1;
         end else begin
            d = (mode == 3) ? TMO - 1 : int'($urandom_range(0, 6));
            idle(d);
            if (mode == 1 && i == k) begin
               w = wrong;
               while (w == 4'd0 || w == good) w = rb();
               emit(1'b1, 1'($urandom), w, rr());
               m_turn = 0; m_lose = 1; over = 1;
            end else begin
               emit(1'b1, 1'($urandom), good, rr());
            end
         end
      end
      if (!over) begin
         m_turn = 0;
         if (m_level == MAX_LEN) begin
            m_win = 1;
            over = 1;
         end else begin
            busy(GAP);
         end
      end
   endtask

   task automatic game(input int pin_seed, input int f0, input int f1, input int f2,
                       input int mode, input int bad_round, input int k,
                       input logic [3:0] wrong, input int pin_first);
      bit over;
      int fr[3];
      fr[0] = f0; fr[1] = f1; fr[2] = f2;
      over = 0;
      start_seq(pin_seed);
      for (int r = 0; r < MAX_LEN && !over; r++) begin
         append(fr[r]);
         if (r == 0) pin_next = pin_first;
         show();
         play((r == bad_round) ? mode : 0, k, wrong, over);
      end
      pin_next = m_win ? 3 : 4;
      hold(3);
   endtask

   task automatic check_row(input int j, input row_t r);
      n_vec++;
      if (seed_o !== r.seed || loadseed_o !== r.ld || led_o !== r.led || turn_o !== r.turn ||
          level_o !== LW'(r.level) || win_o !== r.win || lose_o !== r.lose) begin
         n_bad++;
         $display("FAIL outputs row %0d: got seed=%0d ld=%b led=%b turn=%b lvl=%0d win=%b lose=%b; want seed=%0d ld=%b led=%b turn=%b lvl=%0d win=%b lose=%b",
                  j, seed_o, loadseed_o, led_o, turn_o, level_o, win_o, lose_o,
                  r.seed, r.ld, r.led, r.turn, r.level, r.win, r.lose);
      end
      if (r.pin != 0) begin
         n_vec++;
         case (r.pin)
            1: if (!(seed_o === 32'd37 && loadseed_o === 1'b1)) begin
                  n_bad++;
                  $display("FAIL seed_pin: got seed=%0d ld=%b, want seed=37 ld=1", seed_o, loadseed_o);
               end
            2: if (!(led_o === 4'b0100 && level_o === LW'(1))) begin
                  n_bad++;
                  $display("FAIL first_led_pin: got led=%b lvl=%0d, want led=0100 lvl=1", led_o, level_o);
               end
            3: if (!(win_o === 1'b1 && turn_o === 1'b0 && level_o === LW'(3))) begin
                  n_bad++;
                  $display("FAIL win_pin: got win=%b turn=%b lvl=%0d, want win=1 turn=0 lvl=3", win_o, turn_o, level_o);
               end
            4: if (!(lose_o === 1'b1 && turn_o === 1'b0)) begin
                  n_bad++;
                  $display("FAIL lose_pin: got lose=%b turn=%b, want lose=1 turn=0", lose_o, turn_o);
               end
            default: if (!(led_o === 4'b0000 && level_o === LW'(0))) begin
                  n_bad++;
                  $display("FAIL reset_pin: got led=%b lvl=%0d, want led=0000 lvl=0", led_o, level_o);
               end
         endcase
      end
   endtask

   initial begin
      do_reset(3);
      while (cnt != 37) hold(1);
      // Seed pin, first-round playback, wrong 0001 where 0010 is expected.
      game(1, 2, 1, -1, 1, 1, 1, 4'b0001, 2);
      // Restart from LOSE into a full win with colours 1,3,0.
      game(0, 1, 3, 0, 0, 0, 0, 4'd0, 0);
      // Non-one-hot press 0011 where 0010 is expected.
      game(0, 1, -1, -1, 1, 0, 0, 4'b0011, 0);
      // Presses landing on the 20th idle cycle must still count.
      game(0, -1, -1, -1, 3, 0, 0, 4'd0, 0);
      // Timeout on the first entry of round two.
      game(0, -1, -1, -1, 2, 1, 0, 4'd0, 0);
      // Asynchronous reset in the middle of SHOW_ON.
      start_seq(0);
      append(-1);
      m_led = 4'(1 << seq[0]);
      busy(2);
      pin_next = 5;
      do_reset(2);
      hold(5);
      for (int g = 0; g < 6; g++) begin
         int br;
         br = int'($urandom_range(0, MAX_LEN - 1));
         game(0, -1, -1, -1, int'($urandom_range(0, 3)), br, int'($urandom_range(0, br)), 4'd0, 0);
      end
      hold(2);

      for (int j = 0; j < rows.size(); j++) begin
         @(posedge clk);
         #1;
         reset   = rows[j].rst;
         start_i = rows[j].start;
         btn_i   = rows[j].btn;
         rnd_i   = rows[j].rnd;
         @(negedge clk);
         check_row(j, rows[j]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
